avalon_st_sink_checker: RTL and testbench

// - Downstream consumer of an Avalon-ST source in the sim/verification fabric. It is synthesizable so it can also run on-FPGA.
// - Applies pseudo-random backpressure on ready, reassembles packets from sop/eop and checks framing.
// - Checks the payload against an incrementing-byte pattern and exposes packet/word/byte statistics plus sticky error flags.

---
 rtl/avalon_st_sink_checker.sv | 248 ++++++++++++++++++++++++
 tb/tb_avalon_st_sink_checker.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_st_sink_checker.sv
// avalon_st_sink_checker
//
// Avalon-ST sink for the verification fabric. It can also run on an FPGA.
// - Drives pseudo-random backpressure on in_ready_o from a 16-bit LFSR.
//   The ready latency is 0 and ready never looks at valid.
// - Reassembles packets from sop/eop and flags framing violations.
// - Checks each packet's payload against an incrementing byte pattern that
//   starts at 8'h00 on every sop.
// - Keeps packet, beat and byte statistics plus sticky error flags.
//
// Ports
//   clk_i           single clock, all logic on posedge
//   reset_n_i       synchronous reset, active-low
//   in_valid_i      Avalon-ST valid
//   in_ready_o      Avalon-ST ready (registered)
//   in_data_i       payload; the first byte is in in_data_i[DATA_WIDTH-1 -: 8]
//   in_sop_i        start of packet
//   in_eop_i        end of packet
//   in_empty_i      unused low-order byte lanes on the eop beat
//   clr_stats_i     synchronous clear of the counters and error flags
//   pkt_count_o     packets completed
//   word_count_o    beats accepted
//   byte_count_o    valid bytes accepted
//   last_pkt_len_o  byte length of the last completed packet
//   in_packet_o     FSM is inside a packet
//   err_framing_o   sticky framing error
//   err_payload_o   sticky payload mismatch
//
// State table
//   state     | meaning
//   ST_IDLE   | between packets; a beat without sop here is a framing error
//   ST_IN_PKT | sop accepted, waiting for eop; another sop restarts the packet

module avalon_st_sink_checker #(
    parameter int          DATA_WIDTH  = 64,
    parameter int          EMPTY_WIDTH = 3,
    parameter int          READY_PROB  = 50,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int          CNT_WIDTH   = 32,
    parameter int          LEN_WIDTH   = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [DATA_WIDTH-1:0]  in_data_i,
    input  logic                   in_sop_i,
    input  logic                   in_eop_i,
    input  logic [EMPTY_WIDTH-1:0] in_empty_i,
    input  logic                   clr_stats_i,
    output logic [CNT_WIDTH-1:0]   pkt_count_o,
    output logic [CNT_WIDTH-1:0]   word_count_o,
    output logic [CNT_WIDTH-1:0]   byte_count_o,
    output logic [LEN_WIDTH-1:0]   last_pkt_len_o,
    output logic                   in_packet_o,
    output logic                   err_framing_o,
    output logic                   err_payload_o
);

    localparam int            NB     = DATA_WIDTH / 8;
    // Wide enough to hold NB and any in_empty value without truncation.
    localparam int            BW     = EMPTY_WIDTH + 1;
    localparam logic [BW-1:0] NB_B   = BW'(NB);
    localparam logic [8:0]    THRESH = 9'(READY_PROB * 256 / 100);
    // An all-zero seed would lock the LFSR up.
    localparam logic [15:0]   SEED   = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [15:0]            lfsr_q, lfsr_d;
    logic                   in_ready_q, in_ready_d;
    logic [7:0]             exp_q, exp_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [CNT_WIDTH-1:0]   pkt_q, pkt_d;
    logic [CNT_WIDTH-1:0]   word_q, word_d;
    logic [CNT_WIDTH-1:0]   byte_q, byte_d;
    logic [LEN_WIDTH-1:0]   last_len_q, last_len_d;
    logic                   err_framing_q, err_framing_d;
    logic                   err_payload_q, err_payload_d;

    logic                   accept;
    logic                   lfsr_fb;
    logic [BW-1:0]          empty_ext;
    logic [BW-1:0]          valid_bytes;
    logic                   beat_frm_err;
    logic                   beat_pay_err;
    logic                   check_en;
    logic                   pkt_done;
    logic [7:0]             exp_base;
    logic [LEN_WIDTH-1:0]   len_base;
    logic [LEN_WIDTH:0]     len_sum;
    logic [LEN_WIDTH-1:0]   len_sat;
    logic [7:0]             lane_byte;
    logic [7:0]             lane_exp;

    assign accept = in_valid_i && in_ready_q;

    // Beat decode: valid-byte count, framing violations and packet bases.
    always_comb begin
        empty_ext    = {1'b0, in_empty_i};
        valid_bytes  = NB_B;
        beat_frm_err = 1'b0;

        if (!in_eop_i) begin
            // A non-zero empty on a non-eop beat is flagged and then ignored.
            if (in_empty_i != '0) begin
                beat_frm_err = 1'b1;
            end
        end else if (empty_ext >= NB_B) begin
            beat_frm_err = 1'b1;
            valid_bytes  = '0;
        end else begin
            valid_bytes = NB_B - empty_ext;
        end

        if ((state_q == ST_IN_PKT) && in_sop_i) begin
            beat_frm_err = 1'b1;
        end
        if ((state_q == ST_IDLE) && !in_sop_i) begin
            beat_frm_err = 1'b1;
        end

        // An orphan beat in IDLE is counted but not checked.
        check_en = in_sop_i || (state_q == ST_IN_PKT);
        exp_base = in_sop_i ? 8'h00 : exp_q;
        len_base = in_sop_i ? '0 : len_q;
        len_sum  = {1'b0, len_base} + (LEN_WIDTH + 1)'(valid_bytes);
        len_sat  = len_sum[LEN_WIDTH] ? '1 : len_sum[LEN_WIDTH-1:0];
        pkt_done = accept && check_en && in_eop_i;
    end

    // Payload compare: lane k (k=0 is the MSB byte) must equal exp_base+k.
    always_comb begin
        beat_pay_err = 1'b0;
        lane_byte    = '0;
        lane_exp     = '0;
        for (int k = 0; k < NB; k++) begin
            lane_byte = in_data_i[DATA_WIDTH-1-8*k -: 8];
            lane_exp  = exp_base + 8'(k);
            if ((k < int'(valid_bytes)) && (lane_byte != lane_exp)) begin
                beat_pay_err = 1'b1;
            end
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    if (in_sop_i && !in_eop_i) begin
                        state_d = ST_IN_PKT;
                    end
                end
                ST_IN_PKT: begin
                    if (in_eop_i) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath next state.
    always_comb begin
        lfsr_fb       = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        lfsr_d        = {lfsr_q[14:0], lfsr_fb};
        in_ready_d    = ({1'b0, lfsr_q[7:0]} < THRESH);
        exp_d         = exp_q;
        len_d         = len_q;
        pkt_d         = pkt_q;
        word_d        = word_q;
        byte_d        = byte_q;
        last_len_d    = last_len_q;
        err_framing_d = err_framing_q;
        err_payload_d = err_payload_q;

        if (accept && check_en) begin
            exp_d = exp_base + 8'(valid_bytes);
            len_d = len_sat;
        end

        if (pkt_done) begin
            last_len_d = len_sat;
        end

        // Clear wins over a same-cycle beat; the beat's statistics are dropped.
        if (clr_stats_i) begin
            pkt_d         = '0;
            word_d        = '0;
            byte_d        = '0;
            err_framing_d = 1'b0;
            err_payload_d = 1'b0;
        end else if (accept) begin
            word_d        = word_q + CNT_WIDTH'(1);
            byte_d        = byte_q + CNT_WIDTH'(valid_bytes);
            err_framing_d = err_framing_q | beat_frm_err;
            err_payload_d = err_payload_q | (check_en & beat_pay_err);
            if (pkt_done) begin
                pkt_d = pkt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q       <= ST_IDLE;
            lfsr_q        <= SEED;
            in_ready_q    <= 1'b0;
            exp_q         <= '0;
            len_q         <= '0;
            pkt_q         <= '0;
            word_q        <= '0;
            byte_q        <= '0;
            last_len_q    <= '0;
            err_framing_q <= 1'b0;
            err_payload_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            in_ready_q    <= in_ready_d;
            exp_q         <= exp_d;
            len_q         <= len_d;
            pkt_q         <= pkt_d;
            word_q        <= word_d;
            byte_q        <= byte_d;
            last_len_q    <= last_len_d;
            err_framing_q <= err_framing_d;
            err_payload_q <= err_payload_d;
        end
    end

    assign in_ready_o     = in_ready_q;
    assign pkt_count_o    = pkt_q;
    assign word_count_o   = word_q;
    assign byte_count_o   = byte_q;
    assign last_pkt_len_o = last_len_q;
    assign in_packet_o    = (state_q == ST_IN_PKT);
    assign err_framing_o  = err_framing_q;
    assign err_payload_o  = err_payload_q;

endmodule

// File: tb/tb_avalon_st_sink_checker.sv
// Bench for avalon_st_sink_checker.
//   u_dut : READY_PROB=50 instance carrying the directed and random traffic
//   u_full: READY_PROB=100, LEN_WIDTH=5 (always-ready path, length saturation)
//   u_zero: READY_PROB=0 with valid held high (ready must never assert)
module tb_avalon_st_sink_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    logic        in_valid, in_sop, in_eop, clr_stats, in_ready;
    logic [63:0] in_data;
    logic [2:0]  in_empty;
    logic [31:0] pkt_count, word_count, byte_count;
    logic [15:0] last_pkt_len;
    logic        in_packet, err_framing, err_payload;

    logic        f_valid, f_sop, f_eop, f_clr, f_ready;
    logic [63:0] f_data;
    logic [2:0]  f_empty;
    logic [31:0] f_pkt, f_word, f_byte;
    logic [4:0]  f_last;
    logic        f_inpkt, f_ef, f_ep;

    logic        z_valid, z_sop, z_eop, z_clr, z_ready;
    logic [63:0] z_data;
    logic [2:0]  z_empty;
    logic [31:0] z_pkt, z_word, z_byte;
    logic [15:0] z_last;
    logic        z_inpkt, z_ef, z_ep;

    avalon_st_sink_checker #(.READY_PROB(50)) u_dut (
        .clk_i(clk), .reset_n_i(reset_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_data_i(in_data), .in_sop_i(in_sop), .in_eop_i(in_eop), .in_empty_i(in_empty),
        .clr_stats_i(clr_stats), .pkt_count_o(pkt_count), .word_count_o(word_count),
        .byte_count_o(byte_count), .last_pkt_len_o(last_pkt_len), .in_packet_o(in_packet),
        .err_framing_o(err_framing), .err_payload_o(err_payload));

    avalon_st_sink_checker #(.READY_PROB(100), .LEN_WIDTH(5)) u_full (
        .clk_i(clk), .reset_n_i(reset_n), .in_valid_i(f_valid), .in_ready_o(f_ready),
        .in_data_i(f_data), .in_sop_i(f_sop), .in_eop_i(f_eop), .in_empty_i(f_empty),
        .clr_stats_i(f_clr), .pkt_count_o(f_pkt), .word_count_o(f_word),
        .byte_count_o(f_byte), .last_pkt_len_o(f_last), .in_packet_o(f_inpkt),
        .err_framing_o(f_ef), .err_payload_o(f_ep));

    avalon_st_sink_checker #(.READY_PROB(0)) u_zero (
        .clk_i(clk), .reset_n_i(reset_n), .in_valid_i(z_valid), .in_ready_o(z_ready),
        .in_data_i(z_data), .in_sop_i(z_sop), .in_eop_i(z_eop), .in_empty_i(z_empty),
        .clr_stats_i(z_clr), .pkt_count_o(z_pkt), .word_count_o(z_word),
        .byte_count_o(z_byte), .last_pkt_len_o(z_last), .in_packet_o(z_inpkt),
        .err_framing_o(z_ef), .err_payload_o(z_ep));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pkt;
        logic [31:0] word;
        logic [31:0] bytes;
        logic [15:0] last;
        logic        inpkt;
        logic        ef;
        logic        ep;
    } exp_t;

    exp_t sb_q[$];

    // Reference model of the sink state.
    int m_pkt, m_word, m_byte, m_last, m_len, m_exp;
    bit m_inpkt, m_ef, m_ep;

    bit meas_on = 1'b0;
    int meas_cyc = 0;
    int meas_rdy = 0;
    bit z_ready_seen = 1'b0;

    always @(negedge clk) begin
        if (meas_on) begin
            meas_cyc++;
            if (in_ready) meas_rdy++;
        end
        if (reset_n && z_ready) z_ready_seen = 1'b1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_pkt = 0; m_word = 0; m_byte = 0; m_last = 0; m_len = 0; m_exp = 0;
        m_inpkt = 0; m_ef = 0; m_ep = 0;
    endtask

    task automatic push_exp();
        exp_t e;
        e.pkt   = 32'(m_pkt);
        e.word  = 32'(m_word);
        e.bytes = 32'(m_byte);
        e.last  = 16'(m_last);
        e.inpkt = m_inpkt;
        e.ef    = m_ef;
        e.ep    = m_ep;
        sb_q.push_back(e);
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s.scoreboard: observed=empty expected=entry", tag);
        end else begin
            e = sb_q.pop_front();
            chk({tag, ".pkt"},   {32'h0, pkt_count},    {32'h0, e.pkt});
            chk({tag, ".word"},  {32'h0, word_count},   {32'h0, e.word});
            chk({tag, ".byte"},  {32'h0, byte_count},   {32'h0, e.bytes});
            chk({tag, ".len"},   {48'h0, last_pkt_len}, {48'h0, e.last});
            chk({tag, ".inpkt"}, {63'h0, in_packet},    {63'h0, e.inpkt});
            chk({tag, ".efrm"},  {63'h0, err_framing},  {63'h0, e.ef});
            chk({tag, ".epay"},  {63'h0, err_payload},  {63'h0, e.ep});
        end
    endtask

    task automatic model_beat(input logic [63:0] d, input bit sop, input bit eop,
                              input logic [2:0] emp, input bit clr);
        int nv;
        bit ferr, perr, chk_on, done;
        ferr = 0; perr = 0; chk_on = 0; done = 0;
        if (!eop) begin
            nv = 8;
            if (emp != 3'd0) ferr = 1;
        end else begin
            nv = 8 - int'(emp);
        end
        if (sop) begin
            if (m_inpkt) ferr = 1;
            chk_on = 1; m_exp = 0; m_len = 0;
        end else if (m_inpkt) begin
            chk_on = 1;
        end else begin
            ferr = 1;
        end
        if (chk_on) begin
            for (int k = 0; k < nv; k++)
                if (d[63-8*k -: 8] != 8'((m_exp + k) % 256)) perr = 1;
            m_exp = (m_exp + nv) % 256;
            m_len = (m_len + nv > 65535) ? 65535 : m_len + nv;
            if (eop) begin
                done = 1; m_inpkt = 0; m_last = m_len;
            end else begin
                m_inpkt = 1;
            end
        end
        if (clr) begin
            m_pkt = 0; m_word = 0; m_byte = 0; m_ef = 0; m_ep = 0;
        end else begin
            m_word++;
            m_byte += nv;
            m_ef |= ferr;
            m_ep |= perr;
            if (done) m_pkt++;
        end
    endtask

    function automatic logic [63:0] mk_beat(input int base, input int nv, input int bad_lane);
        logic [63:0] d;
        logic [7:0]  b;
        d = '0;
        for (int k = 0; k < 8; k++) begin
            b = (k < nv) ? 8'((base + k) % 256) : 8'($urandom);
            if (k == bad_lane) b = 8'hFF;
            d[63-8*k -: 8] = b;
        end
        return d;
    endfunction

    // Called just after a negedge; returns just after the negedge that follows acceptance.
    task automatic send_beat(input logic [63:0] d, input bit sop, input bit eop,
                             input logic [2:0] emp, input bit clr, input string tag);
        int n;
        in_data = d; in_sop = sop; in_eop = eop; in_empty = emp;
        in_valid = 1'b1; clr_stats = 1'b0;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk({tag, ".ready_timeout"}, {63'h0, in_ready}, 64'h1);
            in_valid = 1'b0;
        end else begin
            clr_stats = clr;
            model_beat(d, sop, eop, emp, clr);
            push_exp();
            @(negedge clk);
            in_valid = 1'b0; clr_stats = 1'b0;
            pop_cmp(tag);
        end
    endtask

    task automatic send_pkt(input int len, input int bad, input bit idles, input string tag);
        int nb;
        nb = (len + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            bit          last;
            int          nv;
            logic [63:0] d;
            last = (b == nb - 1);
            nv   = last ? len - 8 * b : 8;
            d    = mk_beat(8 * b, nv, bad - 8 * b);
            if (idles && $urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            send_beat(d, b == 0, last, last ? 3'(8 - nv) : 3'd0, 1'b0, tag);
        end
    endtask

    task automatic clear_stats(input string tag);
        in_valid = 1'b0;
        clr_stats = 1'b1;
        m_pkt = 0; m_word = 0; m_byte = 0; m_ef = 0; m_ep = 0;
        push_exp();
        @(negedge clk);
        clr_stats = 1'b0;
        pop_cmp(tag);
    endtask

    task automatic f_beat(input logic [63:0] d, input bit sop, input bit eop, input logic [2:0] emp);
        f_data = d; f_sop = sop; f_eop = eop; f_empty = emp; f_valid = 1'b1;
        chk("full.ready", {63'h0, f_ready}, 64'h1);
        @(negedge clk);
        f_valid = 1'b0;
    endtask

    initial begin
        int sum_len;
        int len;

        reset_n = 1'b0;
        in_valid = 0; in_sop = 0; in_eop = 0; in_empty = 0; in_data = 0; clr_stats = 0;
        f_valid = 0; f_sop = 0; f_eop = 0; f_empty = 0; f_data = 0; f_clr = 0;
        z_valid = 1; z_sop = 1; z_eop = 1; z_empty = 0; z_data = 0; z_clr = 0;
        model_reset();

        repeat (2) @(negedge clk);
        chk("rst.ready", {63'h0, in_ready}, 64'h0);
        chk("rst.full_ready", {63'h0, f_ready}, 64'h0);
        push_exp();
        pop_cmp("rst");
        reset_n = 1'b1;

        // Always-ready instance: ready every cycle, 20-byte packet, then saturation.
        @(negedge clk);
        chk("full.first_ready", {63'h0, f_ready}, 64'h1);
        f_beat(mk_beat(0, 8, -1), 1, 0, 3'd0);
        f_beat(mk_beat(8, 8, -1), 0, 0, 3'd0);
        f_beat(mk_beat(16, 4, -1), 0, 1, 3'd4);
        chk("full.pkt",  {32'h0, f_pkt},  64'd1);
        chk("full.word", {32'h0, f_word}, 64'd3);
        chk("full.byte", {32'h0, f_byte}, 64'd20);
        chk("full.len",  {59'h0, f_last}, 64'd20);
        chk("full.err",  {62'h0, f_ef, f_ep}, 64'h0);
        for (int b = 0; b < 5; b++)
            f_beat(mk_beat(8 * b, 8, -1), b == 0, b == 4, 3'd0);
        chk("full.sat_len", {59'h0, f_last}, 64'd31);
        chk("full.sat_byte", {32'h0, f_byte}, 64'd60);
        chk("full.sat_pkt", {32'h0, f_pkt}, 64'd2);
        chk("full.sat_err", {62'h0, f_ef, f_ep}, 64'h0);

        // Three-beat 20-byte packet on the backpressured instance.
        clear_stats("t1.clr");
        send_pkt(20, -1, 1'b0, "t1");
        chk("t1.pkt_is_1", {32'h0, pkt_count}, 64'd1);
        chk("t1.byte_is_20", {32'h0, byte_count}, 64'd20);

        // Single-beat sop&eop, empty=7.
        clear_stats("t2.clr");
        send_beat(mk_beat(0, 1, -1), 1, 1, 3'd7, 1'b0, "t2");
        chk("t2.len_is_1", {48'h0, last_pkt_len}, 64'd1);

        // Orphan beat in IDLE, then a clean packet.
        clear_stats("t3.clr");
        send_beat(mk_beat(0, 8, -1), 0, 0, 3'd0, 1'b0, "t3.orphan");
        chk("t3.efrm_set", {63'h0, err_framing}, 64'h1);
        send_pkt(16, -1, 1'b0, "t3.pkt");
        chk("t3.efrm_sticky", {63'h0, err_framing}, 64'h1);

        // Corrupted byte 5, then clear.
        clear_stats("t4.clr0");
        send_pkt(16, 5, 1'b0, "t4");
        chk("t4.epay_set", {63'h0, err_payload}, 64'h1);
        clear_stats("t4.clr");
        chk("t4.epay_clr", {63'h0, err_payload}, 64'h0);

        // Non-zero empty on a non-eop beat.
        clear_stats("t5.clr");
        send_beat(mk_beat(0, 8, -1), 1, 0, 3'd3, 1'b0, "t5.b0");
        send_beat(mk_beat(8, 4, -1), 0, 1, 3'd4, 1'b0, "t5.b1");

        // sop inside a packet restarts it.
        clear_stats("t6.clr");
        send_beat(mk_beat(0, 8, -1), 1, 0, 3'd0, 1'b0, "t6.b0");
        send_beat(mk_beat(0, 8, -1), 1, 0, 3'd0, 1'b0, "t6.b1");
        send_beat(mk_beat(8, 8, -1), 0, 1, 3'd0, 1'b0, "t6.b2");
        chk("t6.len_16", {48'h0, last_pkt_len}, 64'd16);

        // clr_stats on the same cycle as an accepted beat.
        clear_stats("t7.clr");
        send_beat(mk_beat(0, 8, -1), 1, 0, 3'd0, 1'b1, "t7.b0");
        send_beat(mk_beat(8, 8, -1), 0, 1, 3'd0, 1'b0, "t7.b1");

        // 1000 random-length packets with ~50% source valid.
        clear_stats("t8.clr");
        sum_len = 0;
        meas_cyc = 0; meas_rdy = 0; meas_on = 1'b1;
        for (int p = 0; p < 1000; p++) begin
            len = $urandom_range(1, 40);
            sum_len += len;
            send_pkt(len, -1, 1'b1, "t8");
        end
        meas_on = 1'b0;
        chk("t8.pkt_1000", {32'h0, pkt_count}, 64'd1000);
        chk("t8.byte_sum", {32'h0, byte_count}, 64'(sum_len));
        chk("t8.no_err", {62'h0, err_framing, err_payload}, 64'h0);
        chk("t8.duty_40_60",
            {63'h0, (meas_rdy * 100 >= meas_cyc * 40) && (meas_rdy * 100 <= meas_cyc * 60)},
            64'h1);

        // Reset mid-packet, then a clean packet.
        send_beat(mk_beat(0, 8, -1), 1, 0, 3'd0, 1'b0, "t9.partial");
        reset_n = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t9.rst_ready", {63'h0, in_ready}, 64'h0);
        model_reset();
        push_exp();
        pop_cmp("t9.rst");
        reset_n = 1'b1;
        send_pkt(24, -1, 1'b0, "t9.pkt");
        chk("t9.len_24", {48'h0, last_pkt_len}, 64'd24);

        chk("zero.never_ready", {63'h0, z_ready_seen}, 64'h0);
        chk("zero.word", {32'h0, z_word}, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
